// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream packet generator:
//   - default TDATA and packet-length widths
//   - FSM state encoding used by axis_pkt_gen
// -----------------------------------------------------------------------------
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_LEN_WIDTH  = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/axis_pkt_gen.sv
// -----------------------------------------------------------------------------
// axis_pkt_gen
// AXI-Stream master that emits one packet per accepted start request.
// Beat k of a packet carries seed + k (mod 2^DATA_WIDTH). TLAST marks the
// final beat. done pulses for one cycle once a packet has finished, including
// a zero-length request, which emits no beats.
//
// Ports
//   ACLK, ARESETn       clock, asynchronous active-low reset
//   start               packet request, sampled only while idle
//   pkt_len, seed       beat count and first-beat data, captured with start
//   TDATA/TVALID/TLAST  stream outputs (all registered)
//   TREADY              downstream ready
//   busy                high while a packet is being sent
//   done                one-cycle completion pulse
//   pkt_cnt, beat_cnt   packets completed and beats transferred
//                       (only present when AXIS_PKT_GEN_STATS_EN is defined)
//
// Build option: define AXIS_PKT_GEN_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
import axis_pkg::*;

module axis_pkt_gen #(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int LEN_WIDTH  = AXIS_LEN_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [DATA_WIDTH-1:0] TDATA,
    output logic                  TVALID,
    output logic                  TLAST,
    input  logic                  TREADY,
    output logic                  busy,
    output logic                  done
`ifdef AXIS_PKT_GEN_STATS_EN
    ,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           beat_cnt
`endif
);

    state_e                state_q, state_d;
    // Beats still to send after the one currently on the bus; TLAST is
    // raised when this reaches zero, so a full-scale pkt_len fits.
    logic [LEN_WIDTH-1:0]  rem_q,    rem_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q,  tlast_d;
    logic                  done_q,   done_d;
    logic                  xfer;

    assign xfer = tvalid_q & TREADY;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        data_d   = data_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (pkt_len != '0) begin
                        state_d  = ST_SEND;
                        rem_d    = pkt_len - LEN_WIDTH'(1);
                        data_d   = seed;
                        tvalid_d = 1'b1;
                        tlast_d  = (pkt_len == LEN_WIDTH'(1));
                    end else begin
                        // Zero-length request completes without any beat.
                        done_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                // start is deliberately not looked at here.
                if (xfer) begin
                    if (tlast_q) begin
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        rem_d   = rem_q - LEN_WIDTH'(1);
                        data_d  = data_q + DATA_WIDTH'(1);
                        tlast_d = (rem_q == LEN_WIDTH'(1));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            data_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
        end
    end

    assign TDATA  = data_q;
    assign TVALID = tvalid_q;
    assign TLAST  = tlast_q;
    assign busy   = (state_q == ST_SEND);
    assign done   = done_q;

`ifdef AXIS_PKT_GEN_STATS_EN
    logic [31:0] pkt_cnt_q,  pkt_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;

    // Both counters wrap naturally at 2^32.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q  + {31'd0, done_d};
        beat_cnt_d = beat_cnt_q + {31'd0, xfer};
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pkt_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pkt_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_gen
// Self-checking bench for axis_pkt_gen: a table of directed cycles, a
// mid-packet reset sequence, randomized traffic against a queue-based model,
// and a maximum-length packet.
// -----------------------------------------------------------------------------
module tb_axis_pkt_gen;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          ACLK    = 1'b0;
    logic          ARESETn = 1'b1;
    logic          start;
    logic [LW-1:0] pkt_len;
    logic [DW-1:0] seed;
    logic [DW-1:0] TDATA;
    logic          TVALID;
    logic          TLAST;
    logic          TREADY;
    logic          busy;
    logic          done;
`ifdef AXIS_PKT_GEN_STATS_EN
    logic [31:0]   pkt_cnt;
    logic [31:0]   beat_cnt;
`endif

    axis_pkt_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .start   (start),
        .pkt_len (pkt_len),
        .seed    (seed),
        .TDATA   (TDATA),
        .TVALID  (TVALID),
        .TLAST   (TLAST),
        .TREADY  (TREADY),
        .busy    (busy),
        .done    (done)
`ifdef AXIS_PKT_GEN_STATS_EN
        ,
        .pkt_cnt (pkt_cnt),
        .beat_cnt(beat_cnt)
`endif
    );

    always #5 ACLK = ~ACLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, then sample just after the rising edge.
    task automatic cyc(input logic st, input logic [LW-1:0] ln, input logic [DW-1:0] sd,
                       input logic rdy);
        @(negedge ACLK);
        start = st; pkt_len = ln; seed = sd; TREADY = rdy;
        @(posedge ACLK);
        #1;
    endtask

    typedef struct {
        logic          st;
        logic [LW-1:0] ln;
        logic [DW-1:0] sd;
        logic          rdy;
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          dn;
        logic          b;
    } vec_t;

    vec_t tbl[$];

    // Reference model: a queue of the beats still owed, {last, data}.
    logic [DW:0] mq[$];
    int          exp_pkts;
    int          exp_beats;

    task automatic rstep(input logic st, input logic [LW-1:0] ln, input logic [DW-1:0] sd,
                         input logic rdy);
        logic        exp_done;
        logic [DW:0] x;
        logic [DW-1:0] dk;
        exp_done = 1'b0;
        if (mq.size() > 0) begin
            if (rdy) begin
                x = mq.pop_front();
                exp_beats++;
                if (x[DW]) begin
                    exp_done = 1'b1;
                    exp_pkts++;
                end
            end
        end else if (st) begin
            if (ln == 0) begin
                exp_done = 1'b1;
                exp_pkts++;
            end else begin
                for (int k = 0; k < int'(ln); k++) begin
                    dk = sd + DW'(k);
                    mq.push_back({(k == int'(ln) - 1), dk});
                end
            end
        end
        cyc(st, ln, sd, rdy);
        chk("rnd_valid", {31'd0, TVALID}, {31'd0, mq.size() > 0});
        chk("rnd_busy",  {31'd0, busy},   {31'd0, mq.size() > 0});
        chk("rnd_done",  {31'd0, done},   {31'd0, exp_done});
        if (mq.size() > 0) begin
            x = mq[0];
            chk("rnd_data", TDATA, x[DW-1:0]);
            chk("rnd_last", {31'd0, TLAST}, {31'd0, x[DW]});
        end
    endtask

    initial begin
        start = 1'b0; pkt_len = '0; seed = '0; TREADY = 1'b0;

        // ---- reset state ----
        #2 ARESETn = 1'b0;
        #10;
        chk("rst_tvalid", {31'd0, TVALID}, 32'd0);
        chk("rst_tlast",  {31'd0, TLAST},  32'd0);
        chk("rst_tdata",  TDATA,           32'd0);
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_done",   {31'd0, done},   32'd0);
`ifdef AXIS_PKT_GEN_STATS_EN
        chk("rst_pkt_cnt",  pkt_cnt,  32'd0);
        chk("rst_beat_cnt", beat_cnt, 32'd0);
`endif
        @(negedge ACLK);
        ARESETn = 1'b1;

        // ---- directed table: {st, len, seed, rdy} -> {valid, data, last, done, busy}
        // four beats from 0x10 with TREADY held high
        tbl.push_back('{1'b1, 16'd4, 32'h10, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b1, 32'h12, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b1, 32'h13, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0});
        // three beats with TREADY 1,0,0,1,0,1
        tbl.push_back('{1'b1, 16'd3, 32'h20, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b1, 32'h21, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b0, 1'b1, 32'h21, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b0, 1'b1, 32'h21, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b1, 32'h22, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b0, 1'b1, 32'h22, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0});
        // data wraps at 2^32
        tbl.push_back('{1'b1, 16'd3, 32'hFFFFFFFE, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0});
        // zero-length request
        tbl.push_back('{1'b1, 16'd0, 32'h55, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0});
        // start during SEND ignored; start on the done cycle accepted
        tbl.push_back('{1'b1, 16'd1, 32'h5,  1'b1, 1'b1, 32'h5,  1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 16'd2, 32'h99, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 16'd2, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 16'd5, 32'h77, 1'b1, 1'b1, 32'h41, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 16'd0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            cyc(tbl[i].st, tbl[i].ln, tbl[i].sd, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), {31'd0, TVALID}, {31'd0, tbl[i].v});
            chk($sformatf("tbl%0d_last",  i), {31'd0, TLAST},  {31'd0, tbl[i].l});
            chk($sformatf("tbl%0d_done",  i), {31'd0, done},   {31'd0, tbl[i].dn});
            chk($sformatf("tbl%0d_busy",  i), {31'd0, busy},   {31'd0, tbl[i].b});
            if (tbl[i].v)
                chk($sformatf("tbl%0d_data", i), TDATA, tbl[i].d);
        end

        // ---- reset in the middle of an 8-beat packet ----
        cyc(1'b1, 16'd8, 32'h100, 1'b1);
        cyc(1'b0, 16'd0, 32'h0,   1'b1);
        cyc(1'b0, 16'd0, 32'h0,   1'b1);
        chk("mid_pre_data", TDATA, 32'h102);
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_tvalid", {31'd0, TVALID}, 32'd0);
        chk("mid_rst_busy",   {31'd0, busy},   32'd0);
        chk("mid_rst_tdata",  TDATA,           32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'd0, 32'h0, 1'b1);
            chk("mid_rst_no_done",  {31'd0, done},   32'd0);
            chk("mid_rst_no_valid", {31'd0, TVALID}, 32'd0);
        end
        @(negedge ACLK);
        ARESETn = 1'b1;
        start = 1'b1; pkt_len = 16'd1; seed = 32'hAB; TREADY = 1'b1;
        @(posedge ACLK);
        #1;
        chk("post_rst_valid", {31'd0, TVALID}, 32'd1);
        chk("post_rst_data",  TDATA,           32'hAB);
        chk("post_rst_last",  {31'd0, TLAST},  32'd1);
        cyc(1'b0, 16'd0, 32'h0, 1'b1);
        chk("post_rst_done",  {31'd0, done},   32'd1);
        chk("post_rst_idle",  {31'd0, TVALID}, 32'd0);
`ifdef AXIS_PKT_GEN_STATS_EN
        chk("stats_pkt1",  pkt_cnt,  32'd1);
        chk("stats_beat1", beat_cnt, 32'd1);
`endif
        cyc(1'b1, 16'd0, 32'h0, 1'b0);
        chk("zero_len_done", {31'd0, done}, 32'd1);
`ifdef AXIS_PKT_GEN_STATS_EN
        chk("stats_pkt2",  pkt_cnt,  32'd2);
        chk("stats_beat2", beat_cnt, 32'd1);
`endif
        cyc(1'b0, 16'd0, 32'h0, 1'b0);

        // ---- randomized traffic against the queue model ----
        exp_pkts  = 2;
        exp_beats = 1;
        for (int i = 0; i < 3000; i++) begin
            logic          st, rdy;
            logic [LW-1:0] ln;
            logic [DW-1:0] sd;
            st  = ($urandom % 3) == 0;
            ln  = LW'($urandom % 8);
            sd  = (($urandom % 4) == 0) ? (32'hFFFFFFFC + ($urandom % 4)) : $urandom;
            rdy = ($urandom % 4) != 0;
            rstep(st, ln, sd, rdy);
        end
        for (int i = 0; i < 20; i++)
            rstep(1'b0, 16'd0, 32'h0, 1'b1);
        chk("rnd_drained", mq.size(), 32'd0);
`ifdef AXIS_PKT_GEN_STATS_EN
        chk("stats_rnd_pkt",  pkt_cnt,  32'(exp_pkts));
        chk("stats_rnd_beat", beat_cnt, 32'(exp_beats));
`endif

        // ---- maximum packet length ----
        begin
            int          nbeats;
            logic        seen_last;
            logic [31:0] last_data;
            nbeats    = 0;
            seen_last = 1'b0;
            last_data = '0;
            cyc(1'b1, 16'hFFFF, 32'h1000, 1'b1);
            for (int i = 0; i < 70000 && !seen_last; i++) begin
                if (TVALID) begin
                    nbeats++;
                    if (TLAST) begin
                        seen_last = 1'b1;
                        last_data = TDATA;
                    end
                end
                cyc(1'b0, 16'd0, 32'h0, 1'b1);
            end
            chk("max_len_last_seen", {31'd0, seen_last}, 32'd1);
            chk("max_len_beats",     32'(nbeats),        32'd65535);
            chk("max_len_last_data", last_data,          32'h00010FFE);
            chk("max_len_done",      {31'd0, done},      32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, TDATA width in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of the packet-length input.
REQ-003 SHALL have one clock and an asynchronous active-low reset, named as below.
REQ-004 ACLK  input  1  rising-edge clock.
REQ-005 ARESETn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request one packet; sampled only in IDLE.
REQ-007 pkt_len  input  LEN_WIDTH  beats per packet; captured with start.
REQ-008 seed  input  DATA_WIDTH  first-beat data value; captured with start.
REQ-009 TDATA  output  DATA_WIDTH  stream data (AXI-Stream master side).
REQ-010 TVALID  output  1  beat valid.
REQ-011 TLAST  output  1  final beat of packet.
REQ-012 TREADY  input  1  downstream ready.
REQ-013 busy  output  1  high while in SEND.
REQ-014 done  output  1  one-cycle pulse at packet completion.

Function
REQ-015 SHALL implement FSM states IDLE and SEND only.
REQ-016 IDLE: start=1 and pkt_len!=0 -> capture pkt_len and seed, go to SEND. TVALID SHALL be high on the next cycle, giving 1-cycle latency.
REQ-017 IDLE: start=1 and pkt_len==0 -> stay in IDLE, emit no beats, and pulse done on the next cycle.
REQ-018 start SHALL be ignored while in SEND, and the captured length and seed SHALL be unaffected.
REQ-019 Beat k SHALL carry TDATA = seed + k (k = 0..len-1), computed modulo 2^DATA_WIDTH with silent wrap.
REQ-020 A beat SHALL transfer only on a clock edge with TVALID=1 and TREADY=1.
REQ-021 Once TVALID=1, TVALID, TDATA and TLAST SHALL hold stable until the beat transfers.
REQ-022 TVALID SHALL NOT depend combinationally on TREADY, and all outputs SHALL be registered.
REQ-023 TLAST SHALL be 1 only on beat len-1; with len=1, the single beat SHALL carry TLAST=1.
REQ-024 In SEND, TVALID SHALL stay continuously high across beats, giving 1 beat per cycle under TREADY=1.
REQ-025 On the TLAST transfer, the FSM SHALL go to IDLE, drop TVALID and TLAST, and pulse done on the next cycle.
REQ-026 start SHALL be accepted in the same cycle done is high, allowing back-to-back packets with 1 idle cycle.
REQ-027 The internal beat counter SHALL be LEN_WIDTH bits, and pkt_len = 2^LEN_WIDTH-1 SHALL be fully supported.

Reset
REQ-028 ARESETn low SHALL asynchronously force IDLE and set TVALID=0, TLAST=0, TDATA=0, busy=0, done=0, and clear all counters.
REQ-029 Reset mid-packet SHALL abort the packet with no further beats, and done SHALL NOT pulse.
REQ-030 Release of reset SHALL be synchronous to ACLK, with the first start accepted on the first edge after release.

Configuration
REQ-031 With AXIS_PKT_GEN_STATS_EN defined, the module SHALL add outputs pkt_cnt (32 bits, packets completed incl. zero-length) and beat_cnt (32 bits, beats transferred); both SHALL reset to 0, wrap at 2^32 and update the cycle after the event.
REQ-032 Without AXIS_PKT_GEN_STATS_EN, these ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 The FSM state enum and the default DATA_WIDTH/LEN_WIDTH constants SHALL live in shared package axis_pkg.
REQ-034 The block SHALL be a single module with no sub-module, exposing the stream signals compatibly with the team's AXI-Stream master modport.

Verification
REQ-035 seed=0x10, len=4, TREADY=1 -> TDATA 0x10,0x11,0x12,0x13 on consecutive cycles; TLAST on 0x13 only; done 1 cycle later.
REQ-036 len=3, TREADY toggling 1,0,0,1,0,1 -> exactly 3 transfers; TDATA/TLAST stable during every stall; no dropped or duplicate beat.
REQ-037 seed=0xFFFFFFFE, len=3 -> TDATA 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 with TLAST on the last.
REQ-038 len=0 start -> no TVALID, done pulses next cycle; with STATS_EN, pkt_cnt=1 and beat_cnt=0.
REQ-039 start during SEND with a different len/seed -> ignored; the current packet completes unchanged; start on the done cycle -> next packet TVALID 1 cycle later.
REQ-040 ARESETn asserted after beat 2 of len=8 -> TVALID=0 immediately, no done; a fresh start with len=1 after release -> single beat with TLAST=1.
